// File: rtl/bht_predictor.sv
// Per-PC branch history table: DEPTH saturating counters, two lookups, one EX update.
// Optional global-history index hashing is enabled with `define BHT_GSHARE_EN.
module bht_predictor #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic [PC_W-1:0]   lk0_pc,
  output logic              lk0_taken,
  input  logic [PC_W-1:0]   lk1_pc,
  output logic              lk1_taken,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic [STAT_W-1:0] mispred_cnt
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] INIT_VAL = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                      state, state_nxt;
  logic [IDX_W-1:0]            init_ptr;
  logic [DEPTH-1:0][CNT_W-1:0] cnt_tab;
  logic [IDX_W-1:0]            hist;
  logic [IDX_W-1:0]            idx0, idx1, idxu;
  logic [CNT_W-1:0]            cur, cnt_nxt;
  logic                        upd_en;

  // Only the index bits of each PC participate in the lookup.
  logic unused_pc;
  assign unused_pc = ^{lk0_pc[PC_W-1:IDX_W+2], lk0_pc[1:0],
                       lk1_pc[PC_W-1:IDX_W+2], lk1_pc[1:0],
                       upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr;
  assign hist = ghr;

  // History is cleared through the sweep; updates shift in the actual outcome.
  always_ff @(posedge clk) begin
    if (rst || state == INIT) ghr <= '0;
    else if (upd_valid)       ghr <= {ghr[IDX_W-2:0], upd_taken};
  end
`else
  assign hist = '0;
`endif

  assign idx0   = lk0_pc[IDX_W+1:2] ^ hist;
  assign idx1   = lk1_pc[IDX_W+1:2] ^ hist;
  assign idxu   = upd_pc[IDX_W+1:2] ^ hist;

  assign ready     = (state == RUN);
  assign lk0_taken = ready & cnt_tab[idx0][CNT_W-1];
  assign lk1_taken = ready & cnt_tab[idx1][CNT_W-1];
  assign upd_en    = ready & upd_valid;

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_ptr == IDX_W'(DEPTH-1)) state_nxt = RUN;
  end

  always_comb begin
    cur     = cnt_tab[idxu];
    cnt_nxt = cur;
    if (upd_taken) begin
      if (cur != CNT_MAX) cnt_nxt = cur + CNT_W'(1);
    end else begin
      if (cur != '0)      cnt_nxt = cur - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      init_ptr    <= '0;
      mispred_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_ptr <= init_ptr + IDX_W'(1);
      if (upd_en && (upd_taken != upd_pred) && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + STAT_W'(1);
    end
  end

  // Table has no reset; the sweep initialises it after every rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) cnt_tab[init_ptr] <= INIT_VAL;
      else if (upd_en)   cnt_tab[idxu]     <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench for bht_predictor: stimulus queues expectations, a negedge monitor checks them.
module tb_bht_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic        ready, lk0_taken, lk1_taken;
  logic [31:0] lk0_pc, lk1_pc, upd_pc;
  logic        upd_valid, upd_taken, upd_pred;
  logic [15:0] mispred_cnt;
  logic        s_ready, s_lk0, s_lk1;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  bht_predictor dut (
    .clk(clk), .rst(rst), .ready(ready),
    .lk0_pc(lk0_pc), .lk0_taken(lk0_taken),
    .lk1_pc(lk1_pc), .lk1_taken(lk1_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .mispred_cnt(mispred_cnt)
  );

  // Narrow statistic copy to reach saturation in a few cycles.
  bht_predictor #(.STAT_W(3)) sat_dut (
    .clk(clk), .rst(rst), .ready(s_ready),
    .lk0_pc(lk0_pc), .lk0_taken(s_lk0),
    .lk1_pc(lk1_pc), .lk1_taken(s_lk1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .mispred_cnt(s_cnt)
  );

  typedef struct {
    string      name;
    logic [3:0] mask;   // 0 ready, 1 lk0, 2 lk1, 3 mispred counts
    logic       rdy, t0, t1;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      int   sat;
      e = q.pop_front();
      if (e.mask[0]) begin
        checks++;
        if (ready !== e.rdy) begin
          errors++;
          $display("FAIL %s ready got %0b want %0b", e.name, ready, e.rdy);
        end
      end
      if (e.mask[1]) begin
        checks++;
        if (lk0_taken !== e.t0) begin
          errors++;
          $display("FAIL %s lk0_taken got %0b want %0b", e.name, lk0_taken, e.t0);
        end
      end
      if (e.mask[2]) begin
        checks++;
        if (lk1_taken !== e.t1) begin
          errors++;
          $display("FAIL %s lk1_taken got %0b want %0b", e.name, lk1_taken, e.t1);
        end
      end
      if (e.mask[3]) begin
        sat = (e.cnt > 7) ? 7 : e.cnt;
        checks += 2;
        if (mispred_cnt !== 16'(e.cnt)) begin
          errors++;
          $display("FAIL %s mispred_cnt got %0d want %0d", e.name, mispred_cnt, e.cnt);
        end
        if (s_cnt !== 3'(sat)) begin
          errors++;
          $display("FAIL %s sat mispred_cnt got %0d want %0d", e.name, s_cnt, sat);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, queue what the outputs must show this cycle, advance.
  task automatic cyc(input string nm, input logic v, input logic [31:0] upc,
                     input logic tk, input logic pd, input logic [31:0] p0, input logic [31:0] p1,
                     input logic [3:0] m, input logic r, input logic e0, input logic e1,
                     input int c);
    exp_t e;
    upd_valid = v; upd_pc = upc; upd_taken = tk; upd_pred = pd;
    lk0_pc = p0; lk1_pc = p1;
    e.name = nm; e.mask = m; e.rdy = r; e.t0 = e0; e.t1 = e1; e.cnt = c;
    q.push_back(e);
    step();
  endtask

  // Called the cycle after the rst edge: 64 not-ready cycles, updates injected mid-sweep.
  task automatic sweep(input string nm);
    for (int i = 0; i < 64; i++) begin
      logic inj;
      inj = (i == 10 || i == 11);
      cyc(nm, inj, 32'h100, 1'b1, 1'b0, 32'(i) << 2, (32'(i) << 2) | 32'h103,
          4'b1111, 1'b0, 1'b0, 1'b0, 0);
    end
    cyc({nm, "_done"}, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 32'h104,
        4'b1111, 1'b1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired with %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_pred = 1'b0;
    lk0_pc = '0; lk1_pc = '0;
    step();
    rst = 1'b0;
    sweep("sweep1");
    for (int k = 0; k < 4; k++)
      cyc("cold", 1'b0, 0, 1'b0, 1'b0, 32'(k) * 32'h44 + 32'h8, 32'hFFFF_FFFC - 32'(k) * 4,
          4'b1111, 1'b1, 1'b0, 1'b0, 0);

    //   name     v     pc        tk    pd    lk0       lk1       mask     rdy   t0    t1   cnt
    cyc("trainA", 1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 32'h104, 4'b1111, 1'b1, 1'b0, 1'b0, 0);
    cyc("trainB", 1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 32'h104, 4'b1111, 1'b1, 1'b1, 1'b0, 1);
    cyc("satHi",  1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 32'h104, 4'b1111, 1'b1, 1'b1, 1'b0, 1);
    cyc("dec11",  1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 32'h104, 4'b1111, 1'b1, 1'b1, 1'b0, 1);
    cyc("dec10",  1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 32'h104, 4'b1111, 1'b1, 1'b1, 1'b0, 2);
    cyc("dec01",  1'b1, 32'h100, 1'b0, 1'b0, 32'h100, 32'h104, 4'b1111, 1'b1, 1'b0, 1'b0, 3);
    cyc("satLo",  1'b1, 32'h100, 1'b0, 1'b0, 32'h100, 32'h104, 4'b1111, 1'b1, 1'b0, 1'b0, 3);
    cyc("from00", 1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 32'h104, 4'b1111, 1'b1, 1'b0, 1'b0, 3);
    cyc("bypass", 1'b1, 32'h200, 1'b1, 1'b0, 32'h100, 32'h200, 4'b1111, 1'b1, 1'b0, 1'b0, 4);
    cyc("alias",  1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 32'h200, 4'b1111, 1'b1, 1'b1, 1'b1, 5);
    cyc("novld",  1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 32'h200, 4'b1111, 1'b1, 1'b1, 1'b1, 5);
    cyc("novld2", 1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 32'h200, 4'b1111, 1'b1, 1'b1, 1'b1, 5);

    rst = 1'b1;
    cyc("rstRun", 1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 32'h200, 4'b1111, 1'b1, 1'b1, 1'b1, 5);
    rst = 1'b0;
    sweep("sweep2");
    cyc("wiped",  1'b0, 32'h0,   1'b0, 1'b0, 32'h200, 32'h100, 4'b1111, 1'b1, 1'b0, 1'b0, 0);

    for (int k = 0; k < 10; k++)
      cyc("statSat", 1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 32'h0, 4'b1001, 1'b1, 1'b0, 1'b0, k);
    upd_valid = 1'b0;

    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
